palette_mapper: RTL



---
 rtl/colormap_pkg.sv | 39 +++
 rtl/blink_timer.sv | 32 +++
 rtl/palette_mapper.sv | 109 ++++++++++
 3 files changed

// File: rtl/colormap_pkg.sv
// Shared types, state codes and default colours for the board-game palette.
// Default colours are stored as 8:8:8 and widened or narrowed by the mapper.
package colormap_pkg;

  localparam int RGB_W_DEF = 24;

  typedef logic [RGB_W_DEF-1:0] rgb_t;

  typedef struct packed {
    logic blink_en;
    rgb_t rgb;
  } pal_entry_t;

  localparam int ST_EMPTY    = 0;
  localparam int ST_WATER    = 1;
  localparam int ST_WATER_HIT = 2;
  localparam int ST_SHIP     = 3;
  localparam int ST_SHIP_HIT = 4;

  localparam rgb_t C_BLACK     = 24'h000000;
  localparam rgb_t C_WATER     = 24'h006994;
  localparam rgb_t C_WATER_HIT = 24'h666666;
  localparam rgb_t C_SHIP      = 24'h808080;
  localparam rgb_t C_SHIP_HIT  = 24'h202020;

  function automatic rgb_t default_rgb(input int idx);
    rgb_t c;
    case (idx)
      ST_EMPTY:     c = C_BLACK;
      ST_WATER:     c = C_WATER;
      ST_WATER_HIT: c = C_WATER_HIT;
      ST_SHIP:      c = C_SHIP;
      ST_SHIP_HIT:  c = C_SHIP_HIT;
      default:      c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame-pulse counter producing the blink phase; toggles every BLINK_FRAMES
// frames. Ports: clk, rst_n, frame_start_i (pulse), phase_o (1 = off phase).
module blink_timer #(
  parameter int BLINK_FRAMES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  output logic phase_o
);

  localparam int CW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      phase_o <= 1'b0;
    end else if (frame_start_i) begin
      if (cnt == LAST) begin
        cnt     <= '0;
        phase_o <= ~phase_o;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/palette_mapper.sv
// Cell-state to RGB mapper with writable palette, blink and 1-cycle latency.
// Ports: state/pix_valid/frame_start/wr_* in; rgb_o, rgb_valid_o, blink_phase_o out.
module palette_mapper
  import colormap_pkg::*;
#(
  parameter int               STATE_W      = 3,
  parameter int               NUM_ENTRIES  = 5,
  parameter int               RGB_W        = 24,
  parameter int               BLINK_FRAMES = 15,
  parameter logic [RGB_W-1:0] BLINK_RGB    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_i,
  input  logic               pix_valid_i,
  input  logic               frame_start_i,
  input  logic               wr_en_i,
  input  logic [STATE_W-1:0] wr_addr_i,
  input  logic [RGB_W:0]     wr_data_i,
  output logic [RGB_W-1:0]   rgb_o,
  output logic               rgb_valid_o,
  output logic               blink_phase_o
);

  localparam int CW = RGB_W / 3;

  typedef struct packed {
    logic             blink_en;
    logic [RGB_W-1:0] rgb;
  } entry_t;

  // Per-channel fit of an 8-bit default to CW bits: keep MSBs when
  // narrower, replicate the channel pattern when wider.
  function automatic logic [RGB_W-1:0] fit(input rgb_t c);
    logic [RGB_W-1:0] r;
    int s;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int b = 0; b < CW; b++) begin
        s = 8 * ch + 7 - (b % 8);
        r[CW*ch + CW-1-b] = c[s];
      end
    end
    return r;
  endfunction

  entry_t           pal [NUM_ENTRIES];
  entry_t           cur;
  entry_t           wr_entry;
  logic             hit;
  logic             phase;
  logic [RGB_W-1:0] pix_rgb;

  assign wr_entry = wr_data_i;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start_i),
    .phase_o       (phase)
  );

  assign blink_phase_o = phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        pal[i].blink_en <= 1'b0;
        pal[i].rgb      <= fit(default_rgb(i));
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (wr_en_i && int'(wr_addr_i) == i)
          pal[i] <= wr_entry;
      end
    end
  end

  // Codes beyond the implemented entries never hit and map to black.
  always_comb begin
    hit = 1'b0;
    cur = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (int'(state_i) == i) begin
        hit = 1'b1;
        cur = pal[i];
      end
    end
  end

  always_comb begin
    pix_rgb = '0;
    if (pix_valid_i && hit)
      pix_rgb = (cur.blink_en && phase) ? BLINK_RGB : cur.rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_o       <= '0;
      rgb_valid_o <= 1'b0;
    end else begin
      rgb_o       <= pix_rgb;
      rgb_valid_o <= pix_valid_i;
    end
  end

endmodule
